// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative 32-bit divider (div_unit).
package div_unit_pkg;

  localparam int DIV_STEPS = 32;
  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } div_state_t;

  // Operands captured at request time; raw values are kept for sign fixup
  // and for the divide-by-zero result.
  typedef struct packed {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
  } div_op_t;

  // Magnitude of a 32-bit operand (two's complement when signed and negative).
  function automatic logic [31:0] mag(input logic [31:0] x, input logic sgn);
    return (sgn && x[31]) ? -x : x;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration on 32-bit magnitudes.
// The dividend is shifted out of the quotient register MSB-first while
// quotient bits are shifted in at the bottom.
module div_step (
  input  logic [31:0] rem_i,
  input  logic [31:0] quo_i,
  input  logic [31:0] dsr_i,
  output logic [31:0] rem_o,
  output logic [31:0] quo_o
);

  logic [32:0] shifted;
  logic [32:0] diff;

  // Trial subtract; keep it only when the shifted remainder covers the divisor.
  always_comb begin
    shifted = {rem_i, quo_i[31]};
    diff    = shifted - {1'b0, dsr_i};
    if (shifted >= {1'b0, dsr_i}) begin
      rem_o = diff[31:0];
      quo_o = {quo_i[30:0], 1'b1};
    end else begin
      rem_o = shifted[31:0];
      quo_o = {quo_i[30:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Iterative 32-bit DIV/DIVU: IDLE -> BUSY (32 steps) -> DONE.
// Result is {HI = remainder, LO = quotient}; ready_o pulses for one cycle.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the iterations and
// goes straight to DONE.
module div_unit
  import div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        busy_o
);

  localparam logic [5:0] LAST_STEP = 6'(DIV_STEPS - 1);

  div_state_t  state;
  div_op_t     op;
  logic [5:0]  cnt;
  logic [31:0] rem, quo, dsr;
  logic [31:0] rem_nx, quo_nx;
  logic [63:0] final_res;
  logic        q_neg, r_neg;

  div_step u_step (
    .rem_i (rem),
    .quo_i (quo),
    .dsr_i (dsr),
    .rem_o (rem_nx),
    .quo_o (quo_nx)
  );

  // Sign fixup of the magnitude result; a zero divisor overrides everything.
  always_comb begin
    q_neg = op.sgn & (op.a[31] ^ op.b[31]);
    r_neg = op.sgn & op.a[31];
    if (op.b == '0)
      final_res = {op.a, DIV_ZERO_Q};
    else
      final_res = {(r_neg ? -rem : rem), (q_neg ? -quo : quo)};
  end

  assign busy_o = (state == S_BUSY);

  // Control FSM plus datapath registers; annul wins over any state.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= S_IDLE;
      op       <= '0;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      dsr      <= '0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      ready_o <= 1'b0;
      if (annul_i) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_i) begin
              op  <= '{sgn: signed_i, a: opdata1_i, b: opdata2_i};
              rem <= '0;
              quo <= mag(opdata1_i, signed_i);
              dsr <= mag(opdata2_i, signed_i);
              cnt <= '0;
`ifdef DIV_ZERO_FAST_EN
              state <= (opdata2_i == '0) ? S_DONE : S_BUSY;
`else
              state <= S_BUSY;
`endif
            end
          end
          S_BUSY: begin
            // Requester withdrew: abandon silently.
            if (!start_i) begin
              state <= S_IDLE;
            end else begin
              rem <= rem_nx;
              quo <= quo_nx;
              cnt <= cnt + 6'd1;
              if (cnt == LAST_STEP) state <= S_DONE;
            end
          end
          S_DONE: begin
            result_o <= final_res;
            ready_o  <= 1'b1;
            state    <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset; all state changes on the rising edge of clk.
REQ-002 SHALL provide: clk  in  1  pipeline clock.
REQ-003 SHALL provide: resetn  in  1  synchronous active-low reset.
REQ-004 SHALL provide: start_i  in  1  divide request (StartDivE), held high by the pipeline until ready_o is seen.
REQ-005 SHALL provide: signed_i  in  1  1 = DIV (signed), 0 = DIVU.
REQ-006 SHALL provide: opdata1_i  in  32  dividend.
REQ-007 SHALL provide: opdata2_i  in  32  divisor.
REQ-008 SHALL provide: annul_i  in  1  exception flush; abort the current operation.
REQ-009 SHALL provide: result_o  out  64  {HI = remainder, LO = quotient}.
REQ-010 SHALL provide: ready_o  out  1  result valid (DivReadyE); one-cycle pulse.
REQ-011 SHALL provide: busy_o  out  1  high in BUSY state.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-013 IDLE: start_i=1 and annul_i=0 at an edge SHALL latch signed_i, opdata1_i and opdata2_i, load operand magnitudes, clear the 6-bit iteration counter, and move to BUSY.
REQ-014 BUSY SHALL perform one restoring shift-subtract step per cycle on 32-bit magnitudes; after the 32nd step it SHALL move to DONE.
REQ-015 Latency: with start_i first sampled at edge k, ready_o SHALL be high exactly between edges k+33 and k+34.
REQ-016 DONE SHALL assert ready_o for one cycle, drive the final result_o, and return to IDLE unconditionally.
REQ-017 Back-to-back requests: start_i high in the cycle after DONE SHALL be treated as a new request from IDLE.
REQ-018 Operand inputs SHALL be ignored after latching; input changes during BUSY SHALL not affect the result.
REQ-019 Signed mode: quotient sign SHALL be sign(dividend) XOR sign(divisor); remainder sign SHALL equal sign(dividend); negation is two's complement on 32 bits.
REQ-020 0x80000000 / 0xFFFFFFFF signed SHALL yield quotient 0x80000000 and remainder 0 (wrap, no trap).
REQ-021 Divisor zero SHALL yield LO=0xFFFFFFFF and HI=opdata1 (raw), independent of signed_i.
REQ-022 annul_i=1 in any state SHALL force IDLE on the next edge, with ready_o=0 on that cycle and result_o unchanged.
REQ-023 start_i dropping to 0 while BUSY SHALL abort the operation to IDLE with no ready_o pulse.
REQ-024 annul_i and start_i both high in IDLE SHALL not start an operation.
REQ-025 result_o SHALL hold the last completed value until the next DONE.

Reset
REQ-026 resetn=0 at an edge SHALL force IDLE, ready_o=0, busy_o=0, result_o=0, and counter 0, including mid-operation.

Configuration
REQ-027 With DIV_ZERO_FAST_EN defined, a zero divisor seen in IDLE SHALL go directly to DONE, so ready_o is high between edges k+1 and k+2.
REQ-028 Without DIV_ZERO_FAST_EN, a zero divisor SHALL take the full 33-edge latency; its result SHALL be per REQ-021 in both builds.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding, DIV_STEPS=32, and the divide-by-zero quotient constant 32'hFFFFFFFF.
REQ-030 One combinational sub-module, div_step, SHALL implement a single restoring iteration: {partial remainder, quotient} plus divisor in, next pair out.

Verification
REQ-031 Unsigned 100/7 with start held -> ready_o high at edge k+33, result_o = {HI=0x00000002, LO=0x0000000E}.
REQ-032 Signed -7/2 -> result_o = {0xFFFFFFFF, 0xFFFFFFFD}; signed 7/-2 -> {0x00000001, 0xFFFFFFFD}.
REQ-033 Divisor zero, dividend 0x12345678 -> {0x12345678, 0xFFFFFFFF}; latency 1 with DIV_ZERO_FAST_EN, 33 without.
REQ-034 annul_i pulse at cycle 10 of BUSY -> IDLE next edge, no ready_o, result_o keeps its previous value.
REQ-035 Two divides back-to-back (start_i high through DONE) -> two ready_o pulses 34 cycles apart, each with the correct result.
REQ-036 resetn low at cycle 5 of BUSY -> all outputs 0 next edge; a subsequent request of 9/3 completes with {0, 3}.
